// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two
// valid/ready requesters; operands and results are registered here.
module alu_arbiter #(
    parameter int WIDTH = 16,
    parameter int CMD_W = 3,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_op1,
    input  logic [WIDTH-1:0] req0_op2,
    input  logic [CMD_W-1:0] req0_cmd,
    output logic             rsp0_valid,
    input  logic             rsp0_ready,
    output logic [WIDTH-1:0] rsp0_res,
    output logic             rsp0_eq,
    output logic             rsp0_ovf,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_op1,
    input  logic [WIDTH-1:0] req1_op2,
    input  logic [CMD_W-1:0] req1_cmd,
    output logic             rsp1_valid,
    input  logic             rsp1_ready,
    output logic [WIDTH-1:0] rsp1_res,
    output logic             rsp1_eq,
    output logic             rsp1_ovf,
    output logic [WIDTH-1:0] alu_op1,
    output logic [WIDTH-1:0] alu_op2,
    output logic [CMD_W-1:0] alu_cmd,
    input  logic [WIDTH-1:0] alu_res,
    input  logic             alu_eq,
    input  logic             alu_ovf,
    output logic             busy,
    output logic [CNT_W-1:0] op_cnt
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic             owner_q;
    logic             last_grant_q;
    logic [WIDTH-1:0] op1_q, op1_d;
    logic [WIDTH-1:0] op2_q, op2_d;
    logic [CMD_W-1:0] cmd_q, cmd_d;
    logic [WIDTH-1:0] res0_q, res1_q;
    logic             eq0_q, eq1_q;
    logic             ovf0_q, ovf1_q;
    logic [CNT_W-1:0] cnt_q;

    logic gnt_vld;
    logic gnt_port;
    logic req_hs;
    logic rsp_hs;

    // Port 1 wins when it is alone, or on a tie when port 0 went last.
    assign gnt_vld  = req0_valid | req1_valid;
    assign gnt_port = req1_valid & (~req0_valid | ~last_grant_q);

    assign req_hs = (req0_valid & req0_ready)
                  | (req1_valid & req1_ready);
    assign rsp_hs = (rsp0_valid & rsp0_ready)
                  | (rsp1_valid & rsp1_ready);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: if (req_hs) state_d = S_EXEC;
            S_EXEC: state_d = S_RESP;
            S_RESP: if (rsp_hs) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        rsp0_valid = 1'b0;
        rsp1_valid = 1'b0;
        busy       = 1'b1;
        unique case (state_q)
            S_IDLE: begin
                busy       = 1'b0;
                req0_ready = gnt_vld & ~gnt_port;
                req1_ready = gnt_vld & gnt_port;
            end
            S_EXEC: begin
                busy = 1'b1;
            end
            S_RESP: begin
                rsp0_valid = ~owner_q;
                rsp1_valid = owner_q;
            end
            default: begin
                busy = 1'b1;
            end
        endcase
    end

    always_comb begin
        op1_d = op1_q;
        op2_d = op2_q;
        cmd_d = cmd_q;
        if (req_hs) begin
            op1_d = gnt_port ? req1_op1 : req0_op1;
            op2_d = gnt_port ? req1_op2 : req0_op2;
            cmd_d = gnt_port ? req1_cmd : req0_cmd;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op1_q        <= '0;
            op2_q        <= '0;
            cmd_q        <= '0;
            owner_q      <= 1'b0;
            last_grant_q <= 1'b1;
        end else begin
            op1_q <= op1_d;
            op2_q <= op2_d;
            cmd_q <= cmd_d;
            if (req_hs) begin
                owner_q      <= gnt_port;
                last_grant_q <= gnt_port;
            end
        end
    end

    // ALU outputs are captured at the end of the single EXEC cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res0_q <= '0;
            eq0_q  <= 1'b0;
            ovf0_q <= 1'b0;
            res1_q <= '0;
            eq1_q  <= 1'b0;
            ovf1_q <= 1'b0;
        end else if (state_q == S_EXEC) begin
            if (owner_q) begin
                res1_q <= alu_res;
                eq1_q  <= alu_eq;
                ovf1_q <= alu_ovf;
            end else begin
                res0_q <= alu_res;
                eq0_q  <= alu_eq;
                ovf0_q <= alu_ovf;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (rsp_hs) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign alu_op1  = op1_q;
    assign alu_op2  = op2_q;
    assign alu_cmd  = cmd_q;
    assign rsp0_res = res0_q;
    assign rsp0_eq  = eq0_q;
    assign rsp0_ovf = ovf0_q;
    assign rsp1_res = res1_q;
    assign rsp1_eq  = eq1_q;
    assign rsp1_ovf = ovf1_q;
    assign op_cnt   = cnt_q;

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares the single combinational 16-bit ALU (OP1/OP2/cmd -> RES/eq_bit/ovF) between two requesters, e.g. the execute stage (port 0) and the branch/address helper (port 1).
- Each requester has a valid/ready request channel and a valid/ready response channel.
- Arbitration is round-robin; the block registers the ALU operands and result.
- The block sits between the requesters and one alu instance.

Parameters:
- WIDTH, 16, operand/result width; must match the alu.
- CMD_W, 3, ALU command width.
- CNT_W, 16, width of the completed-operation counter.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- req0_valid  in  1  port-0 request valid.
- req0_ready  out  1  port-0 request accepted this cycle.
- req0_op1, req0_op2  in  WIDTH  port-0 operands, signed.
- req0_cmd  in  CMD_W  port-0 ALU command.
- rsp0_valid  out  1  port-0 response valid.
- rsp0_ready  in  1  port-0 response consumed.
- rsp0_res  out  WIDTH  port-0 result.
- rsp0_eq  out  1  port-0 eq_bit.
- rsp0_ovf  out  1  port-0 ovF.
- req1_*, rsp1_*  same widths and meaning, for port 1.
- alu_op1, alu_op2  out  WIDTH  registered operands to the alu.
- alu_cmd  out  CMD_W  registered command to the alu.
- alu_res  in  WIDTH  ALU RES.
- alu_eq  in  1  ALU eq_bit.
- alu_ovf  in  1  ALU ovF.
- busy  out  1  high whenever state != IDLE.
- op_cnt  out  CNT_W  count of completed response handshakes; wraps to 0 after all-ones.

Behaviour:
- Command encoding, passed to the alu unchanged:
  - 000 add, 001 sub, 010 sll, 100 srl, 011 greater-than (res=1 if op1>op2 signed, else 0).
  - 101/110/111 are forwarded as-is; the response carries whatever the alu returns; no error flag.
- FSM states: IDLE, EXEC, RESP.
- IDLE, grant selection (combinational):
  - Only one port valid: grant that port.
  - Both valid: grant the port != last_grant.
  - req_ready is high only for the granted port, and only in IDLE.
  - On handshake (valid & ready): latch op1/op2/cmd into alu_* regs, set owner and last_grant = granted port, go to EXEC.
- EXEC, exactly one cycle:
  - alu_* are stable for the whole cycle.
  - At the end of the cycle, capture alu_res/alu_eq/alu_ovf into the owner's rsp regs and go to RESP.
- RESP:
  - rspN_valid is high for the owner only.
  - Holds until rspN_ready. On the handshake, rsp_valid drops next cycle, op_cnt increments, and the FSM returns to IDLE.
  - rsp data is stable while valid & !ready.
- Latency and throughput:
  - Request accepted at edge N -> rsp_valid high at edge N+2.
  - With rsp_ready held high, minimum issue interval is 3 cycles per operation.
- No request is accepted in EXEC or RESP; both req_ready are low.
- The non-owner port's rsp_valid is always 0.
- Responses always return to the port that issued the request, never to the other port.
- Reset values:
  - state=IDLE, last_grant=1 (port 0 wins the first tie).
  - alu_op1=alu_op2=0, alu_cmd=000.
  - All rsp_valid=0; rsp_res=0, rsp_eq=0, rsp_ovf=0.
  - busy=0, op_cnt=0.
- Reset mid-operation (rst_n low in EXEC or RESP): the pending operation is discarded and no response is ever produced. After release the FSM is in IDLE and arbitration restarts from last_grant=1.
- A request withdrawn before ready: legal, no state change.
- Request operands and command are sampled only on the handshake edge; later changes have no effect.
- Arithmetic: no width extension; result, eq and overflow come from the alu only. The arbiter never modifies data.

Test Plan:
- Single add: port 0 op1=5, op2=7, cmd=000 accepted at edge N -> rsp0_valid at N+2, res=12, ovf=0; rsp1_valid stays 0.
- Overflow/sub: port 1 op1=32767, op2=1, cmd=000 -> res=-32768, ovf=1. Then op1=-32768, op2=1, cmd=001 -> res=32767, ovf=1.
- Tie after reset: both ports valid in the same cycle with distinct ops -> port 0 served first, then port 1. With both held valid continuously the grants alternate 0,1,0,1; op_cnt=4 after four response handshakes.
- Backpressure: port-0 sll op1=3, op2=4 -> rsp0_valid with res=48; hold rsp0_ready low 3 cycles -> res stays 48, req0_ready and req1_ready stay low, busy=1; raise ready -> IDLE next cycle.
- Compare/shift: cmd=011, op1=-2, op2=1 -> res=0. Then cmd=100, op1=16'h8000, op2=15 -> res=1.
- Reset mid-op: assert rst_n low during EXEC -> all outputs at reset values immediately; no rsp_valid ever seen for that op; the next request is accepted in the cycle after release.
